util_adc_diff: RTL and testbench

UTIL_ADC_DIFF -- requirements
Module: util_adc_diff

---
 rtl/util_adc_diff.sv | 85 ++++++++
 tb/tb_util_adc_diff.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/util_adc_diff.sv
// Differential ADC sampler: synchronizes a P/N pair, packs four
// 2-bit samples per byte and offers them on a one-entry AXI-Stream.
module util_adc_diff #(
  parameter int unsigned RATE_DIV = 1
) (
  input  logic       aclk,
  input  logic       arstn,
  input  logic       en,
  input  logic [1:0] diff_in,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       overflow
);

  localparam int unsigned RW =
    (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [RW-1:0] RMAX = RW'(RATE_DIV - 1);

  logic [1:0]    sync1_q, sync2_q;
  logic [RW-1:0] rate_q, rate_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    pack_q, pack_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          ovf_q, ovf_d;

  logic       tick, done, accept, load;
  logic [7:0] byte_w;

  always_comb begin
    tick   = en && (rate_q == RMAX);
    byte_w = {pack_q[5:0], sync2_q};
    done   = tick && (cnt_q == 2'd3);
    accept = tvalid_q && m_axis_tready;
    load   = done && (!tvalid_q || m_axis_tready);

    rate_d = rate_q;
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (!en) begin
      // idle: drop any partial byte and realign to [7:6]
      rate_d = '0;
      cnt_d  = '0;
      pack_d = '0;
    end else if (tick) begin
      rate_d = '0;
      cnt_d  = cnt_q + 2'd1;
      pack_d = byte_w;
    end else begin
      rate_d = rate_q + 1'b1;
    end

    tvalid_d = load || (tvalid_q && !accept);
    tdata_d  = load ? byte_w : tdata_q;
    ovf_d    = done && tvalid_q && !m_axis_tready;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      pack_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= diff_in;
      sync2_q  <= sync1_q;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_util_adc_diff.sv
// Directed-vector and reference-model bench for util_adc_diff.
module tb_util_adc_diff;

  logic       aclk;
  logic       arstn;
  logic       en1, rdy1, tv1, ov1;
  logic [1:0] diff1;
  logic [7:0] td1;
  logic       en4, rdy4, tv4, ov4;
  logic [1:0] diff4;
  logic [7:0] td4;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic       en;
    logic       rdy;
    logic [1:0] diff;
    logic       tv;
    logic [7:0] td;
    logic       ov;
  } vec_t;

  vec_t tbl [36];

  util_adc_diff #(.RATE_DIV(1)) dut1 (
    .aclk          (aclk),
    .arstn         (arstn),
    .en            (en1),
    .diff_in       (diff1),
    .m_axis_tdata  (td1),
    .m_axis_tvalid (tv1),
    .m_axis_tready (rdy1),
    .overflow      (ov1)
  );

  util_adc_diff #(.RATE_DIV(4)) dut4 (
    .aclk          (aclk),
    .arstn         (arstn),
    .en            (en4),
    .diff_in       (diff4),
    .m_axis_tdata  (td4),
    .m_axis_tvalid (tv4),
    .m_axis_tready (rdy4),
    .overflow      (ov4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    step();
    step();
    arstn = 1'b1;
  endtask

  initial begin
    logic [1:0] pat [8];
    logic [1:0] s1m, s2m, samp, cnt;
    logic [7:0] pack, mtd;
    logic       mtv, movf, acc;
    int         drops, ovcnt, got;
    bit         seen;

    tbl[0]  = {1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
    tbl[1]  = {1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
    tbl[2]  = {1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
    tbl[3]  = {1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
    tbl[4]  = {1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0};
    tbl[5]  = {1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[6]  = {1'b1, 1'b1, 2'b01, 1'b1, 8'hAA, 1'b0};
    tbl[7]  = {1'b1, 1'b1, 2'b01, 1'b0, 8'hAA, 1'b0};
    tbl[8]  = {1'b1, 1'b0, 2'b01, 1'b0, 8'hAA, 1'b0};
    tbl[9]  = {1'b1, 1'b0, 2'b11, 1'b0, 8'hAA, 1'b0};
    tbl[10] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[11] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[12] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[13] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[14] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b1};
    tbl[15] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[16] = {1'b1, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0};
    tbl[17] = {1'b1, 1'b0, 2'b10, 1'b1, 8'h55, 1'b0};
    tbl[18] = {1'b1, 1'b0, 2'b01, 1'b1, 8'h55, 1'b1};
    tbl[19] = {1'b1, 1'b0, 2'b00, 1'b1, 8'h55, 1'b0};
    tbl[20] = {1'b1, 1'b1, 2'b11, 1'b0, 8'h55, 1'b0};
    tbl[21] = {1'b1, 1'b1, 2'b11, 1'b0, 8'h55, 1'b0};
    tbl[22] = {1'b1, 1'b1, 2'b11, 1'b1, 8'h93, 1'b0};
    tbl[23] = {1'b0, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[24] = {1'b0, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[25] = {1'b0, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[26] = {1'b0, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[27] = {1'b1, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[28] = {1'b1, 1'b1, 2'b11, 1'b0, 8'h93, 1'b0};
    tbl[29] = {1'b0, 1'b1, 2'b00, 1'b0, 8'h93, 1'b0};
    tbl[30] = {1'b0, 1'b1, 2'b10, 1'b0, 8'h93, 1'b0};
    tbl[31] = {1'b1, 1'b1, 2'b01, 1'b0, 8'h93, 1'b0};
    tbl[32] = {1'b1, 1'b1, 2'b00, 1'b0, 8'h93, 1'b0};
    tbl[33] = {1'b1, 1'b1, 2'b00, 1'b0, 8'h93, 1'b0};
    tbl[34] = {1'b1, 1'b1, 2'b00, 1'b1, 8'h24, 1'b0};
    tbl[35] = {1'b0, 1'b1, 2'b00, 1'b0, 8'h24, 1'b0};

    pat[0] = 2'b10; pat[1] = 2'b01;
    pat[2] = 2'b00; pat[3] = 2'b11;
    pat[4] = 2'b10; pat[5] = 2'b00;
    pat[6] = 2'b01; pat[7] = 2'b11;

    arstn = 1'b0;
    en1 = 1'b0; rdy1 = 1'b1; diff1 = 2'b00;
    en4 = 1'b0; rdy4 = 1'b1; diff4 = 2'b00;
    step();
    step();
    chk("rst_tvalid", 32'(tv1), 32'(0));
    chk("rst_tdata", 32'(td1), 32'(0));
    chk("rst_ovf", 32'(ov1), 32'(0));
    arstn = 1'b1;

    // RATE_DIV=1: AA stream, overflow under backpressure, en drop
    for (int i = 0; i < 36; i++) begin
      en1   = tbl[i].en;
      rdy1  = tbl[i].rdy;
      diff1 = tbl[i].diff;
      step();
      chk($sformatf("tbl%0d", i),
          32'({tv1, td1, ov1}),
          32'({tbl[i].tv, tbl[i].td, tbl[i].ov}));
    end

    // reset while a byte is held
    en1 = 1'b1; rdy1 = 1'b0; diff1 = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = tv1;
    end
    chk("held_before_rst", 32'(tv1), 32'(1));
    #2 arstn = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(tv1), 32'(0));
    chk("async_rst_tdata", 32'(td1), 32'(0));
    step();
    step();
    arstn = 1'b1;
    rdy1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("post_rst_tv%0d", i),
          32'(tv1), 32'(i == 4));
    end
    chk("post_rst_tdata", 32'(td1), 32'(8'h0A));
    en1 = 1'b0;

    // RATE_DIV=4 packing order
    do_reset();
    diff4 = 2'b10;
    for (int i = 0; i < 3; i++) step();
    for (int r = 0; r < 32; r++) begin
      en4   = 1'b1;
      diff4 = pat[r/4];
      step();
      chk($sformatf("r4_tv%0d", r), 32'(tv4),
          32'(r == 15 || r == 31));
      if (r == 15) chk("r4_byte0", 32'(td4), 32'(8'h93));
      if (r == 31) chk("r4_byte1", 32'(td4), 32'(8'h87));
    end
    chk("r4_ovf", 32'(ov4), 32'(0));
    en4 = 1'b0;

    // random backpressure against a reference model
    en1 = 1'b1; rdy1 = 1'b1;
    do_reset();
    s1m = '0; s2m = '0; cnt = '0; pack = '0;
    mtv = 1'b0; mtd = '0; movf = 1'b0;
    drops = 0; ovcnt = 0; got = 0;
    for (int c = 0; c < 10000; c++) begin
      diff1 = 2'($urandom);
      rdy1  = 1'($urandom);
      samp = s2m;
      s2m  = s1m;
      s1m  = diff1;
      acc  = mtv && rdy1;
      if (acc) got++;
      movf = 1'b0;
      pack = {pack[5:0], samp};
      if (cnt == 2'd3) begin
        if (!mtv || rdy1) begin
          mtd = pack;
          mtv = 1'b1;
        end else begin
          movf = 1'b1;
          drops++;
        end
      end else if (acc) begin
        mtv = 1'b0;
      end
      cnt = cnt + 2'd1;
      step();
      if (ov1) ovcnt++;
      chk($sformatf("rnd%0d", c),
          32'({tv1, td1, ov1}),
          32'({mtv, mtd, movf}));
    end
    chk("ovf_count", 32'(ovcnt), 32'(drops));
    chk("bytes_moved", 32'(got > 100), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
